instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader_pkg.sv | 15 +
 rtl/instruction_loader_if.sv | 29 ++
 rtl/instruction_loader_word_assembler.sv | 36 +++
 rtl/instruction_loader.sv | 97 +++++++++
 tb/tb_instruction_loader.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared loader/fetch constants: instruction-memory geometry, halt marker, FSM encoding.
// Combinational definitions only; no latency and no flow control.
package instruction_loader_pkg;

    localparam int          INSTR_SIZE    = 32;
    localparam int          IMEM_ADDR_W   = 14;
    localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RECV  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Wires only; the byte strobe has no ready, so the stream cannot be backpressured.
interface instruction_loader_if
    import instruction_loader_pkg::*;
#(
    parameter int SIZE   = INSTR_SIZE,
    parameter int ADDR_W = IMEM_ADDR_W
);
    logic              i_start;
    logic              i_byte_valid;
    logic [7:0]        i_byte;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [SIZE-1:0]   o_mem_data;
    logic              o_cpu_hold;
    logic              o_done;
    logic              o_error;
    logic [ADDR_W:0]   o_word_count;

    modport master (
        output i_start, i_byte_valid, i_byte,
        input  o_mem_we, o_mem_addr, o_mem_data, o_cpu_hold, o_done, o_error, o_word_count
    );

    modport slave (
        input  i_start, i_byte_valid, i_byte,
        output o_mem_we, o_mem_addr, o_mem_data, o_cpu_hold, o_done, o_error, o_word_count
    );
endinterface

// File: rtl/instruction_loader_word_assembler.sv
// Big-endian byte-to-word shifter; o_word/o_word_ready are combinational with the 4th byte.
// No backpressure: every accepted strobe is consumed in the cycle it arrives.
module word_assembler #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_accept,
    input  logic            i_byte_valid,
    input  logic [7:0]      i_byte,
    output logic [SIZE-1:0] o_word,
    output logic            o_word_ready
);
    // Only the three most recent bytes need storing; the fourth arrives on i_byte.
    logic [SIZE-9:0] r_shift;
    logic [1:0]      r_cnt;
    logic            w_take;

    assign w_take       = i_accept & i_byte_valid;
    assign o_word       = {r_shift, i_byte};
    assign o_word_ready = w_take && (r_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shift <= '0;
            r_cnt   <= 2'd0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= 2'd0;
        end else if (w_take) begin
            r_shift <= o_word[SIZE-9:0];
            r_cnt   <= r_cnt + 2'd1;
        end
    end
endmodule

// File: rtl/instruction_loader.sv
// Loads a byte stream into instruction memory until the halt word; o_mem_we is one cycle after the 4th byte.
// No backpressure: a byte strobed during the write cycle becomes byte 0 of the next word.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int              SIZE      = INSTR_SIZE,
    parameter int              ADDR_W    = IMEM_ADDR_W,
    parameter logic [SIZE-1:0] HALT_WORD = DEF_HALT_WORD
) (
    input  logic               clk,
    input  logic               rst,
    instruction_loader_if.slave bus
);
    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_word_count;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [SIZE-1:0]   r_mem_data;
    logic              r_done;
    logic              r_error;
    logic              r_cpu_hold;
    logic              w_accept;
    logic              w_clear;
    logic [SIZE-1:0]   w_word;
    logic              w_word_ready;

    assign w_accept = (r_state == ST_RECV) || (r_state == ST_WRITE);
    assign w_clear  = bus.i_start && !w_accept;

    word_assembler #(.SIZE(SIZE)) u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_accept     (w_accept),
        .i_byte_valid (bus.i_byte_valid),
        .i_byte       (bus.i_byte),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: if (bus.i_start) w_next = ST_RECV;
            ST_RECV:                    if (w_word_ready) w_next = ST_WRITE;
            ST_WRITE: begin
                // Halt takes priority so a halt word in the last slot still ends in DONE.
                if (r_mem_data == HALT_WORD) w_next = ST_DONE;
                else if (r_addr == '1)       w_next = ST_ERROR;
                else                         w_next = ST_RECV;
            end
            default:                    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_word_count <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_cpu_hold   <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_mem_we   <= (w_next == ST_WRITE);
            r_done     <= (w_next == ST_DONE);
            r_error    <= (w_next == ST_ERROR);
            r_cpu_hold <= (w_next != ST_DONE);
            if (w_next == ST_WRITE) begin
                r_mem_addr <= r_addr;
                r_mem_data <= w_word;
            end
            if (r_state == ST_WRITE) begin
                r_addr       <= r_addr + 1'b1;
                r_word_count <= r_word_count + 1'b1;
            end
            if (w_clear) begin
                r_addr       <= '0;
                r_word_count <= '0;
            end
        end
    end

    assign bus.o_mem_we     = r_mem_we;
    assign bus.o_mem_addr   = r_mem_addr;
    assign bus.o_mem_data   = r_mem_data;
    assign bus.o_done       = r_done;
    assign bus.o_error      = r_error;
    assign bus.o_cpu_hold   = r_cpu_hold;
    assign bus.o_word_count = r_word_count;
endmodule

// File: tb/tb_instruction_loader.sv
// Randomised bench for instruction_loader: a byte-stream reference model predicts every memory write.
module tb_instruction_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    instruction_loader_if #(.SIZE(32), .ADDR_W(14)) bus ();
    instruction_loader_if #(.SIZE(32), .ADDR_W(2))  bus_s ();

    instruction_loader #(.SIZE(32), .ADDR_W(14), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    instruction_loader #(.SIZE(32), .ADDR_W(2), .HALT_WORD(32'hFFFF_FFFF)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s));

    // Observed writes and model expectations
    int          addr_q[$];
    logic [31:0] data_q[$];
    int          sa_q[$];
    logic [31:0] sd_q[$];
    logic [7:0]  byte_q[$];
    int          exp_a[$];
    logic [31:0] exp_d[$];

    always @(negedge clk) begin
        if (bus.o_mem_we) begin
            addr_q.push_back(int'(bus.o_mem_addr));
            data_q.push_back(bus.o_mem_data);
        end
        if (bus_s.o_mem_we) begin
            sa_q.push_back(int'(bus_s.o_mem_addr));
            sd_q.push_back(bus_s.o_mem_data);
        end
    end

    // Reference: group accepted bytes big-endian into words, stop at halt or a full memory.
    task automatic model_build(input int aw);
        logic [31:0] w = 32'h0;
        int n = 0;
        int a = 0;
        exp_a.delete();
        exp_d.delete();
        for (int i = 0; i < byte_q.size(); i++) begin
            w = {w[23:0], byte_q[i]};
            n++;
            if (n == 4) begin
                n = 0;
                exp_a.push_back(a);
                exp_d.push_back(w);
                if (w == 32'hFFFF_FFFF || a == (1 << aw) - 1) break;
                a++;
            end
        end
    endtask

    task automatic clear_all();
        addr_q.delete(); data_q.delete(); sa_q.delete(); sd_q.delete(); byte_q.delete();
    endtask

    task automatic drv(input logic st, input logic v, input logic [7:0] b);
        bus.i_start = st; bus.i_byte_valid = v; bus.i_byte = b;
        @(posedge clk); #1;
        bus.i_start = 1'b0; bus.i_byte_valid = 1'b0;
    endtask

    task automatic drv_s(input logic st, input logic v, input logic [7:0] b);
        bus_s.i_start = st; bus_s.i_byte_valid = v; bus_s.i_byte = b;
        @(posedge clk); #1;
        bus_s.i_start = 1'b0; bus_s.i_byte_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        byte_q.push_back(b);
        drv(1'b0, 1'b1, b);
    endtask

    task automatic send_s(input logic [7:0] b);
        byte_q.push_back(b);
        drv_s(1'b0, 1'b1, b);
    endtask

    task automatic send_halt();
        for (int i = 0; i < 4; i++) send(8'hFF);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus.o_mem_we !== 1'b0 || bus.o_mem_addr !== 14'd0 || bus.o_mem_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_mem we=%b addr=%0d data=%h, need 0/0/0",
                     bus.o_mem_we, bus.o_mem_addr, bus.o_mem_data);
        end
        tests++;
        if (bus.o_done !== 1'b0 || bus.o_error !== 1'b0 || bus.o_word_count !== 15'd0 || bus.o_cpu_hold !== 1'b1) begin
            fails++;
            $display("FAIL reset_status done=%b err=%b cnt=%0d hold=%b, need 0/0/0/1",
                     bus.o_done, bus.o_error, bus.o_word_count, bus.o_cpu_hold);
        end
        tests++;
        if (bus_s.o_cpu_hold !== 1'b1 || bus_s.o_error !== 1'b0 || bus_s.o_word_count !== 3'd0) begin
            fails++;
            $display("FAIL reset_small hold=%b err=%b cnt=%0d, need 1/0/0",
                     bus_s.o_cpu_hold, bus_s.o_error, bus_s.o_word_count);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic_load();
        logic [7:0] prog[8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        clear_all();
        drv(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) send(prog[i]);
        repeat (2) drv(1'b0, 1'b0, 8'h00);
        model_build(14);
        tests++;
        if (addr_q.size() != exp_a.size()) begin
            fails++;
            $display("FAIL basic_nwrites got %0d need %0d", addr_q.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < addr_q.size(); i++) begin
            tests++;
            if (addr_q[i] !== exp_a[i] || data_q[i] !== exp_d[i]) begin
                fails++;
                $display("FAIL basic_write%0d got %0d:%h need %0d:%h", i, addr_q[i], data_q[i], exp_a[i], exp_d[i]);
            end
        end
        tests++;
        if (bus.o_done !== 1'b1 || bus.o_word_count !== 15'd2 || bus.o_cpu_hold !== 1'b0 || bus.o_error !== 1'b0) begin
            fails++;
            $display("FAIL basic_status done=%b cnt=%0d hold=%b err=%b, need 1/2/0/0",
                     bus.o_done, bus.o_word_count, bus.o_cpu_hold, bus.o_error);
        end
    endtask

    task automatic test_write_timing();
        logic [7:0]  b[4];
        logic [31:0] w0;
        logic [31:0] w1;
        clear_all();
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 254));
        w0 = {b[0], b[1], b[2], b[3]};
        drv(1'b1, 1'b1, 8'h99);                       // from DONE; coincident byte dropped
        for (int i = 0; i < 3; i++) send(b[i]);
        tests++;
        if (bus.o_mem_we !== 1'b0) begin
            fails++;
            $display("FAIL early_we got %b need 0", bus.o_mem_we);
        end
        send(b[3]);
        tests++;
        if (bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== 14'd0 || bus.o_mem_data !== w0) begin
            fails++;
            $display("FAIL latency_we we=%b addr=%0d data=%h need 1/0/%h", bus.o_mem_we, bus.o_mem_addr, bus.o_mem_data, w0);
        end
        send(8'hAB);                                  // strobed during the write cycle
        tests++;
        if (bus.o_mem_we !== 1'b0) begin
            fails++;
            $display("FAIL we_one_cycle got %b need 0", bus.o_mem_we);
        end
        for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
        w1 = {8'hAB, b[0], b[1], b[2]};
        for (int i = 0; i < 3; i++) send(b[i]);
        tests++;
        if (bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== 14'd1 || bus.o_mem_data !== w1) begin
            fails++;
            $display("FAIL write_gap_byte we=%b addr=%0d data=%h need 1/1/%h", bus.o_mem_we, bus.o_mem_addr, bus.o_mem_data, w1);
        end
        drv(1'b0, 1'b0, 8'h00);
        send_halt();
        repeat (2) drv(1'b0, 1'b0, 8'h00);
        tests++;
        if (bus.o_done !== 1'b1 || bus.o_word_count !== 15'd3 || addr_q.size() != 3) begin
            fails++;
            $display("FAIL timing_end done=%b cnt=%0d writes=%0d need 1/3/3", bus.o_done, bus.o_word_count, addr_q.size());
        end
    endtask

    task automatic test_random_loads();
        int nw;
        for (int it = 0; it < 4; it++) begin
            clear_all();
            nw = $urandom_range(1, 5);
            drv(1'b1, 1'b1, 8'($urandom));
            for (int w = 0; w < nw; w++) begin
                for (int k = 0; k < 4; k++) begin
                    send(k == 0 ? 8'($urandom_range(0, 254)) : 8'($urandom));
                    repeat ($urandom_range(0, 2)) drv($urandom_range(0, 3) == 0, 1'b0, 8'h00);
                end
            end
            send_halt();
            repeat (2) drv(1'b0, 1'b0, 8'h00);
            model_build(14);
            tests++;
            if (addr_q.size() != exp_a.size()) begin
                fails++;
                $display("FAIL rand%0d_nwrites got %0d need %0d", it, addr_q.size(), exp_a.size());
            end
            for (int i = 0; i < exp_a.size() && i < addr_q.size(); i++) begin
                tests++;
                if (addr_q[i] !== exp_a[i] || data_q[i] !== exp_d[i]) begin
                    fails++;
                    $display("FAIL rand%0d_write%0d got %0d:%h need %0d:%h", it, i, addr_q[i], data_q[i], exp_a[i], exp_d[i]);
                end
            end
            tests++;
            if (bus.o_done !== 1'b1 || int'(bus.o_word_count) != nw + 1) begin
                fails++;
                $display("FAIL rand%0d_status done=%b cnt=%0d need 1/%0d", it, bus.o_done, bus.o_word_count, nw + 1);
            end
        end
    endtask

    task automatic test_start_ignore();
        rst = 1'b0;
        drv(1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        clear_all();
        drv(1'b0, 1'b1, 8'h55);                       // idle byte ignored
        drv(1'b1, 1'b1, 8'h11);                       // start with byte: byte dropped
        send(8'h01); send(8'h02);
        drv(1'b1, 1'b0, 8'h00);                       // mid-load start ignored
        send(8'h03); send(8'h04);
        send_halt();
        repeat (2) drv(1'b0, 1'b0, 8'h00);
        model_build(14);
        tests++;
        if (addr_q.size() != exp_a.size()) begin
            fails++;
            $display("FAIL start_nwrites got %0d need %0d", addr_q.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < addr_q.size(); i++) begin
            tests++;
            if (addr_q[i] !== exp_a[i] || data_q[i] !== exp_d[i]) begin
                fails++;
                $display("FAIL start_write%0d got %0d:%h need %0d:%h", i, addr_q[i], data_q[i], exp_a[i], exp_d[i]);
            end
        end
        tests++;
        if (data_q.size() < 1 || data_q[0] !== 32'h0102_0304 || bus.o_done !== 1'b1) begin
            fails++;
            $display("FAIL start_first_word got %h done=%b need 01020304/1",
                     (data_q.size() > 0) ? data_q[0] : 32'h0, bus.o_done);
        end
    endtask

    task automatic test_reset_midload();
        clear_all();
        drv(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 254)));
        rst = 1'b0;
        drv(1'b0, 1'b0, 8'h00);
        tests++;
        if (bus.o_mem_we !== 1'b0 || bus.o_mem_addr !== 14'd0 || bus.o_mem_data !== 32'd0 ||
            bus.o_done !== 1'b0 || bus.o_error !== 1'b0 || bus.o_word_count !== 15'd0 || bus.o_cpu_hold !== 1'b1) begin
            fails++;
            $display("FAIL midreset_outputs we=%b addr=%0d data=%h done=%b err=%b cnt=%0d hold=%b",
                     bus.o_mem_we, bus.o_mem_addr, bus.o_mem_data, bus.o_done, bus.o_error, bus.o_word_count, bus.o_cpu_hold);
        end
        rst = 1'b1;
        repeat (2) drv(1'b0, 1'b0, 8'h00);
        tests++;
        if (addr_q.size() != 1) begin
            fails++;
            $display("FAIL midreset_partial writes=%0d need 1", addr_q.size());
        end
        drv(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) send(8'($urandom));
        rst = 1'b0;                                   // reset on the edge taking the 4th byte
        drv(1'b0, 1'b1, 8'h42);
        rst = 1'b1;
        repeat (2) drv(1'b0, 1'b0, 8'h00);
        tests++;
        if (addr_q.size() != 1 || bus.o_mem_we !== 1'b0) begin
            fails++;
            $display("FAIL pending_write_suppressed writes=%0d we=%b need 1/0", addr_q.size(), bus.o_mem_we);
        end
        clear_all();
        drv(1'b1, 1'b0, 8'h00);
        send_halt();
        repeat (2) drv(1'b0, 1'b0, 8'h00);
        tests++;
        if (addr_q.size() != 1 || addr_q[0] != 0 || data_q[0] !== 32'hFFFF_FFFF || bus.o_done !== 1'b1) begin
            fails++;
            $display("FAIL reload_addr0 writes=%0d done=%b need 1 write at 0, done=1", addr_q.size(), bus.o_done);
        end
    endtask

    task automatic test_mem_full();
        clear_all();
        drv_s(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) send_s((i % 4 == 0) ? 8'($urandom_range(0, 254)) : 8'($urandom));
        repeat (2) drv_s(1'b0, 1'b0, 8'h00);
        tests++;
        if (bus_s.o_error !== 1'b1 || bus_s.o_word_count !== 3'd4 || bus_s.o_cpu_hold !== 1'b1 || bus_s.o_done !== 1'b0) begin
            fails++;
            $display("FAIL full_status err=%b cnt=%0d hold=%b done=%b need 1/4/1/0",
                     bus_s.o_error, bus_s.o_word_count, bus_s.o_cpu_hold, bus_s.o_done);
        end
        for (int i = 0; i < 4; i++) send_s(8'($urandom));
        repeat (2) drv_s(1'b0, 1'b0, 8'h00);
        model_build(2);
        tests++;
        if (sa_q.size() != exp_a.size() || bus_s.o_error !== 1'b1) begin
            fails++;
            $display("FAIL full_nwrites got %0d err=%b need %0d/1", sa_q.size(), bus_s.o_error, exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < sa_q.size(); i++) begin
            tests++;
            if (sa_q[i] !== exp_a[i] || sd_q[i] !== exp_d[i]) begin
                fails++;
                $display("FAIL full_write%0d got %0d:%h need %0d:%h", i, sa_q[i], sd_q[i], exp_a[i], exp_d[i]);
            end
        end
    endtask

    initial begin
        bus.i_start = 1'b0;   bus.i_byte_valid = 1'b0;   bus.i_byte = 8'h00;
        bus_s.i_start = 1'b0; bus_s.i_byte_valid = 1'b0; bus_s.i_byte = 8'h00;
        test_reset();
        test_basic_load();
        test_write_timing();
        test_random_loads();
        test_start_ignore();
        test_reset_midload();
        test_mem_full();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
